// File: rtl/exu_stage.sv
// exu_stage: two-entry execute stage between IDU and WBU.
// S1 holds the selected ALU operands, S2 holds the registered ALU result.
// Source operands are bypassed from S1 (live ALU result) or S2 when they
// are captured, so dependent instructions issue back to back.
module exu_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [5:0]  in_op_i,
  input  logic [1:0]  in_src1_sel_i,
  input  logic [1:0]  in_src2_sel_i,
  input  logic [4:0]  in_rs1_idx_i,
  input  logic [4:0]  in_rs2_idx_i,
  input  logic [31:0] in_rs1_data_i,
  input  logic [31:0] in_rs2_data_i,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_imm_i,
  input  logic [4:0]  in_rd_i,
  input  logic        in_wen_i,
  input  logic        flush_i,
  output logic [5:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_result_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_result_o,
  output logic [4:0]  out_rd_o,
  output logic        out_wen_o
);

  // S1: operand register
  logic        s1_valid_q, s1_valid_d;
  logic [5:0]  s1_op_q,    s1_op_d;
  logic [31:0] s1_a_q,     s1_a_d;
  logic [31:0] s1_b_q,     s1_b_d;
  logic [4:0]  s1_rd_q,    s1_rd_d;
  logic        s1_wen_q,   s1_wen_d;
  // S2: result register
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_res_q,   s2_res_d;
  logic [4:0]  s2_rd_q,    s2_rd_d;
  logic        s2_wen_q,   s2_wen_d;

  logic        out_fire, s2_free, adv, in_fire;
  logic [31:0] rs1_fwd, rs2_fwd;

  // Youngest producer wins: S1's live ALU result beats S2; x0 never forwards.
  function automatic logic [31:0] fwd(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        s1_v,
    input logic        s1_w,
    input logic [4:0]  s1_rd,
    input logic [31:0] s1_res,
    input logic        s2_v,
    input logic        s2_w,
    input logic [4:0]  s2_rd,
    input logic [31:0] s2_res
  );
    if (s1_v && s1_w && (s1_rd == idx) && (idx != 5'd0))      return s1_res;
    else if (s2_v && s2_w && (s2_rd == idx) && (idx != 5'd0)) return s2_res;
    else                                                      return rf_data;
  endfunction

  assign out_fire   = s2_valid_q & out_ready_i;
  assign s2_free    = ~s2_valid_q | out_fire;
  assign adv        = s1_valid_q & s2_free & ~flush_i;
  assign in_ready_o = (~s1_valid_q | adv) & ~flush_i;
  assign in_fire    = in_valid_i & in_ready_o;

  assign alu_op_o     = s1_valid_q ? s1_op_q : 6'd0;
  assign alu_a_o      = s1_valid_q ? s1_a_q  : 32'd0;
  assign alu_b_o      = s1_valid_q ? s1_b_q  : 32'd0;
  assign out_valid_o  = s2_valid_q;
  assign out_result_o = s2_res_q;
  assign out_rd_o     = s2_rd_q;
  assign out_wen_o    = s2_wen_q;

  // Resolve bypass for both sources against the entries currently in flight.
  always_comb begin
    rs1_fwd = fwd(in_rs1_idx_i, in_rs1_data_i, s1_valid_q, s1_wen_q, s1_rd_q,
                  alu_result_i, s2_valid_q, s2_wen_q, s2_rd_q, s2_res_q);
    rs2_fwd = fwd(in_rs2_idx_i, in_rs2_data_i, s1_valid_q, s1_wen_q, s1_rd_q,
                  alu_result_i, s2_valid_q, s2_wen_q, s2_rd_q, s2_res_q);
  end

  // Next state of S1: capture selected operands on accept, drop on advance or flush.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_rd_d    = s1_rd_q;
    s1_wen_d   = s1_wen_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op_i;
      s1_rd_d    = in_rd_i;
      s1_wen_d   = in_wen_i;
      case (in_src1_sel_i)
        2'd0:    s1_a_d = rs1_fwd;
        2'd1:    s1_a_d = in_pc_i;
        default: s1_a_d = 32'd0;
      endcase
      case (in_src2_sel_i)
        2'd0:    s1_b_d = rs2_fwd;
        2'd1:    s1_b_d = in_imm_i;
        2'd2:    s1_b_d = 32'd4;
        default: s1_b_d = 32'd0;
      endcase
    end else if (adv || flush_i) begin
      s1_valid_d = 1'b0;
    end
  end

  // Next state of S2: load the ALU result on advance, empty when WBU takes it.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_rd_d    = s2_rd_q;
    s2_wen_d   = s2_wen_q;
    if (adv) begin
      s2_valid_d = 1'b1;
      s2_res_d   = alu_result_i;
      s2_rd_d    = s1_rd_q;
      s2_wen_d   = s1_wen_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  // State registers; reset discards both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= 6'd0;
      s1_a_q     <= 32'd0;
      s1_b_q     <= 32'd0;
      s1_rd_q    <= 5'd0;
      s1_wen_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= 32'd0;
      s2_rd_q    <= 5'd0;
      s2_wen_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_rd_q    <= s1_rd_d;
      s1_wen_q   <= s1_wen_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_rd_q    <= s2_rd_d;
      s2_wen_q   <= s2_wen_d;
    end
  end

endmodule

// File: tb/tb_exu_stage.sv
// Testbench for exu_stage: directed sequences, an operand-select table, and a
// randomized run checked against an in-order architectural register model.
module tb_exu_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [5:0]  in_op_i = '0;
  logic [1:0]  in_src1_sel_i = '0, in_src2_sel_i = '0;
  logic [4:0]  in_rs1_idx_i = '0, in_rs2_idx_i = '0;
  logic [31:0] in_rs1_data_i = '0, in_rs2_data_i = '0;
  logic [31:0] in_pc_i = '0, in_imm_i = '0;
  logic [4:0]  in_rd_i = '0;
  logic        in_wen_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [5:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o, alu_result_i;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] out_result_o;
  logic [4:0]  out_rd_o;
  logic        out_wen_o;

  exu_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_op_i(in_op_i), .in_src1_sel_i(in_src1_sel_i), .in_src2_sel_i(in_src2_sel_i),
    .in_rs1_idx_i(in_rs1_idx_i), .in_rs2_idx_i(in_rs2_idx_i),
    .in_rs1_data_i(in_rs1_data_i), .in_rs2_data_i(in_rs2_data_i),
    .in_pc_i(in_pc_i), .in_imm_i(in_imm_i), .in_rd_i(in_rd_i), .in_wen_i(in_wen_i),
    .flush_i(flush_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_result_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_rd_o(out_rd_o), .out_wen_o(out_wen_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      6'd1:    return a - b;
      6'd2:    return a ^ b;
      6'd3:    return a | b;
      6'd4:    return a & b;
      6'd5:    return a << b[4:0];
      default: return a + b;
    endcase
  endfunction

  assign alu_result_i = alu_fn(alu_op_o, alu_a_o, alu_b_o);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [5:0] op, input logic [1:0] s1,
                        input logic [1:0] s2, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd, input logic wen);
    in_valid_i = v; in_op_i = op; in_src1_sel_i = s1; in_src2_sel_i = s2;
    in_rs1_idx_i = r1; in_rs2_idx_i = r2; in_rs1_data_i = d1; in_rs2_data_i = d2;
    in_pc_i = pc; in_imm_i = imm; in_rd_i = rd; in_wen_i = wen;
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  s1, s2;
    logic [31:0] rs1d, rs2d, pc, imm, exp_a, exp_b;
  } sel_vec_t;
  sel_vec_t vecs[6];

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  s1, s2;
    logic [4:0]  r1, r2, rd;
    logic [31:0] pc, imm;
    logic        wen;
  } inst_t;
  inst_t q[$];
  logic [31:0] rf[32];

  function automatic logic [31:0] opa(input logic [1:0] s, input logic [31:0] r, input logic [31:0] pc);
    case (s)
      2'd0:    return r;
      2'd1:    return pc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] opb(input logic [1:0] s, input logic [31:0] r, input logic [31:0] imm);
    case (s)
      2'd0:    return r;
      2'd1:    return imm;
      2'd2:    return 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    int acc;
    logic [31:0] bp_d1[3];
    logic [31:0] bp_d2[3];
    inst_t it, h;
    logic [31:0] ea, eb, er;

    vecs[0] = '{2'd0, 2'd0, 32'd5,      32'd7,      32'd0,          32'd0,          32'd5,          32'd7};
    vecs[1] = '{2'd1, 2'd2, 32'd11,     32'd22,     32'h8000_0000,  32'd0,          32'h8000_0000,  32'd4};
    vecs[2] = '{2'd2, 2'd1, 32'd11,     32'd22,     32'h100,        32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0};
    vecs[3] = '{2'd3, 2'd3, 32'd11,     32'd22,     32'h100,        32'h55,         32'd0,          32'd0};
    vecs[4] = '{2'd0, 2'd1, 32'h1234,   32'd22,     32'h100,        32'h10,         32'h1234,       32'h10};
    vecs[5] = '{2'd1, 2'd0, 32'd11,     32'hABCD,   32'h100,        32'd0,          32'h100,        32'hABCD};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_out_result", out_result_o, 0);
    chk("rst_out_rd", out_rd_o, 0);
    chk("rst_out_wen", out_wen_o, 0);
    chk("rst_alu_op", alu_op_o, 0);
    chk("rst_alu_a", alu_a_o, 0);
    chk("rst_alu_b", alu_b_o, 0);
    rst_n = 1'b1;

    // Single instruction, 2-edge latency
    @(negedge clk);
    out_ready_i = 1'b1;
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
    #1 chk("basic_in_ready", in_ready_o, 1);
    @(negedge clk); idle();
    #1;
    chk("basic_alu_a", alu_a_o, 5);
    chk("basic_alu_b", alu_b_o, 7);
    chk("basic_not_yet_valid", out_valid_o, 0);
    @(negedge clk); #1;
    chk("basic_out_valid", out_valid_o, 1);
    chk("basic_out_result", out_result_o, 12);
    chk("basic_out_rd", out_rd_o, 3);
    chk("basic_out_wen", out_wen_o, 1);
    @(negedge clk); #1;
    chk("basic_drained", out_valid_o, 0);

    // Dependent pair, bypass from S1 with no bubble
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b1);
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd1, 5'd3, 5'd0, 32'd0, 32'd0, 32'd0, 32'd1, 5'd4, 1'b1);
    #1;
    chk("dep_in_ready", in_ready_o, 1);
    chk("dep_i0_alu_a", alu_a_o, 5);
    @(negedge clk); idle();
    #1;
    chk("dep_i1_alu_a", alu_a_o, 12);
    chk("dep_i1_alu_b", alu_b_o, 1);
    chk("dep_i0_result", out_result_o, 12);
    @(negedge clk); #1;
    chk("dep_i1_valid", out_valid_o, 1);
    chk("dep_i1_result", out_result_o, 13);
    chk("dep_i1_rd", out_rd_o, 4);
    @(negedge clk); #1;

    // Back-pressure: 3 offered over 4 stalled cycles
    bp_d1 = '{32'd10, 32'd20, 32'd30};
    bp_d2 = '{32'd1, 32'd2, 32'd3};
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      out_ready_i = 1'b0;
      set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, bp_d1[acc], bp_d2[acc], 32'd0, 32'd0,
             5'(5 + acc), 1'b1);
      #1;
      if (c >= 2) begin
        chk("bp_in_ready_full", in_ready_o, 0);
        chk("bp_s2_stable_result", out_result_o, 11);
        chk("bp_s2_stable_rd", out_rd_o, 5);
      end
      if (in_ready_o) acc++;
    end
    chk("bp_accept_count", acc, 2);
    @(negedge clk);
    out_ready_i = 1'b1;
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, bp_d1[2], bp_d2[2], 32'd0, 32'd0, 5'd7, 1'b1);
    #1;
    chk("bp_accept_on_release", in_ready_o, 1);
    chk("bp_first_out", out_result_o, 11);
    @(negedge clk); idle();
    #1;
    chk("bp_second_out", out_result_o, 22);
    chk("bp_second_rd", out_rd_o, 6);
    chk("bp_third_alu_a", alu_a_o, 30);
    @(negedge clk); #1;
    chk("bp_third_out", out_result_o, 33);
    chk("bp_third_rd", out_rd_o, 7);
    @(negedge clk); #1;
    chk("bp_drained", out_valid_o, 0);

    // Index zero never forwards: from S2, then from S1
    @(negedge clk);
    out_ready_i = 1'b0;
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd9, 32'd1, 32'd0, 32'd0, 5'd0, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1);
    #1;
    chk("x0_s2_holds_rd0", out_rd_o, 0);
    chk("x0_s2_result", out_result_o, 10);
    @(negedge clk); idle();
    #1 chk("x0_from_s2_alu_a", alu_a_o, 0);
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd9, 32'd1, 32'd0, 32'd0, 5'd0, 1'b1);
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd1, 1'b1);
    @(negedge clk); idle();
    #1 chk("x0_from_s1_alu_a", alu_a_o, 0);
    repeat (3) @(negedge clk);

    // Operand-select table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set_in(1, 6'd0, vecs[i].s1, vecs[i].s2, 5'd0, 5'd0, vecs[i].rs1d, vecs[i].rs2d,
             vecs[i].pc, vecs[i].imm, 5'd10, 1'b1);
      @(negedge clk); idle();
      #1;
      chk($sformatf("sel%0d_alu_a", i), alu_a_o, vecs[i].exp_a);
      chk($sformatf("sel%0d_alu_b", i), alu_b_o, vecs[i].exp_b);
      @(negedge clk); #1;
      chk($sformatf("sel%0d_result", i), out_result_o, vecs[i].exp_a + vecs[i].exp_b);
    end
    @(negedge clk);

    // Flush with S1 full and S2 stalled, simultaneous offer
    @(negedge clk);
    out_ready_i = 1'b0;
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd100, 32'd1, 32'd0, 32'd0, 5'd8, 1'b1);
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd200, 32'd2, 32'd0, 32'd0, 5'd9, 1'b1);
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd300, 32'd3, 32'd0, 32'd0, 5'd10, 1'b1);
    flush_i = 1'b1;
    #1 chk("flush_in_ready", in_ready_o, 0);
    @(negedge clk); idle();
    out_ready_i = 1'b1;
    #1;
    chk("flush_s1_dropped_a", alu_a_o, 0);
    chk("flush_s1_dropped_op_b", alu_b_o, 0);
    chk("flush_s2_valid", out_valid_o, 1);
    chk("flush_s2_result", out_result_o, 101);
    chk("flush_s2_rd", out_rd_o, 8);
    @(negedge clk); #1;
    chk("flush_nothing_after", out_valid_o, 0);

    // Asynchronous reset mid-stream
    @(negedge clk);
    out_ready_i = 1'b0;
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd40, 32'd2, 32'd0, 32'd0, 5'd11, 1'b1);
    @(negedge clk);
    set_in(1, 6'd0, 2'd0, 2'd0, 5'd0, 5'd0, 32'd50, 32'd2, 32'd0, 32'd0, 5'd12, 1'b1);
    @(negedge clk); idle();
    #1 chk("arst_pre_valid", out_valid_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid_o, 0);
    chk("arst_out_result", out_result_o, 0);
    chk("arst_alu_a", alu_a_o, 0);
    chk("arst_in_ready", in_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;

    // Randomized run against an in-order register-file model
    rf[0] = 32'd0;
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      it.op  = 6'($urandom_range(0, 6));
      it.s1  = 2'($urandom_range(0, 3));
      it.s2  = 2'($urandom_range(0, 3));
      it.r1  = 5'($urandom_range(0, 7));
      it.r2  = 5'($urandom_range(0, 7));
      it.rd  = 5'($urandom_range(0, 7));
      it.wen = 1'($urandom_range(0, 1));
      it.pc  = $urandom;
      it.imm = $urandom;
      set_in(($urandom_range(0, 3) != 0), it.op, it.s1, it.s2, it.r1, it.r2,
             rf[it.r1], rf[it.r2], it.pc, it.imm, it.rd, it.wen);
      out_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_in_ready", in_ready_o, (q.size() < 2) || out_ready_i);
      if (out_valid_o && out_ready_i) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_output", 1, 0);
        end else begin
          h  = q.pop_front();
          ea = opa(h.s1, rf[h.r1], h.pc);
          eb = opb(h.s2, rf[h.r2], h.imm);
          er = alu_fn(h.op, ea, eb);
          chk("rnd_result", out_result_o, er);
          chk("rnd_rd", out_rd_o, h.rd);
          chk("rnd_wen", out_wen_o, h.wen);
          if (h.wen && h.rd != 5'd0) rf[h.rd] = er;
        end
      end
      if (in_valid_i && in_ready_o) q.push_back(it);
    end
    // Drain everything still in flight
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      idle();
      out_ready_i = 1'b1;
      #1;
      if (out_valid_o) begin
        if (q.size() == 0) begin
          chk("drain_unexpected_output", 1, 0);
        end else begin
          h  = q.pop_front();
          ea = opa(h.s1, rf[h.r1], h.pc);
          eb = opb(h.s2, rf[h.r2], h.imm);
          er = alu_fn(h.op, ea, eb);
          chk("drain_result", out_result_o, er);
          chk("drain_rd", out_rd_o, h.rd);
          if (h.wen && h.rd != 5'd0) rf[h.rd] = er;
        end
      end
    end
    chk("drain_all_delivered", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exu_stage.md
# exu_stage

Two-entry execute stage between the instruction decoder (IDU) and write-back (WBU) in npc. It accepts decoded instructions over a valid/ready handshake and selects ALU operands, including a bypass from older in-flight results. It drives the combinational ALU from an operand register, then registers the ALU result with its destination for WBU. Throughput is one instruction per cycle; back-pressure comes from WBU.

## Interface
- No parameters. Datapath 32 bits, ALU opcode 6 bits, register index 5 bits.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: IDU offers an instruction.
- `in_ready_o` out 1: stage accepts this cycle.
- `in_op_i` in 6: ALU opcode, passed unchanged to the ALU.
- `in_src1_sel_i` in 2: operand A select. 0 = rs1, 1 = pc, 2 = zero, 3 = zero.
- `in_src2_sel_i` in 2: operand B select. 0 = rs2, 1 = imm, 2 = 32'd4, 3 = zero.
- `in_rs1_idx_i`, `in_rs2_idx_i` in 5: source register indices, used for the bypass match.
- `in_rs1_data_i`, `in_rs2_data_i` in 32: register-file read data.
- `in_pc_i`, `in_imm_i` in 32: pc and sign-extended immediate.
- `in_rd_i` in 5, `in_wen_i` in 1: destination register and write enable.
- `flush_i` in 1: kill the younger entry (S1).
- `alu_op_o` out 6, `alu_a_o` out 32, `alu_b_o` out 32: drive the combinational ALU.
- `alu_result_i` in 32: ALU result for `alu_*_o`, same cycle.
- `out_valid_o` out 1, `out_ready_i` in 1: handshake to WBU.
- `out_result_o` out 32, `out_rd_o` out 5, `out_wen_o` out 1: result to WBU.

## Operation
- S1 is the operand register: valid bit, op, A, B, rd, wen. S2 is the result register: valid bit, result, rd, wen.
- `out_fire = out_valid_o & out_ready_i`.
- `s2_free = !s2_valid | out_fire`.
- `adv = s1_valid & s2_free & !flush_i`.
- `in_ready_o = (!s1_valid | adv) & !flush_i`.
- `in_fire = in_valid_i & in_ready_o`.
- ALU outputs always come from S1: `alu_op_o` = S1.op, `alu_a_o` = S1.A, `alu_b_o` = S1.B. All three are 0 when S1 is invalid.
- Bypass is resolved at capture time, separately for rs1 and rs2. Priority, first match wins:
  - (a) S1 valid & S1.wen & S1.rd == idx & idx != 0 → `alu_result_i`.
  - (b) S2 valid & S2.wen & S2.rd == idx & idx != 0 → S2.result.
  - (c) otherwise → `in_rsX_data_i`.
- Index 0 never bypasses; it always reads register-file data.
- After the bypass, apply the src selects to form A and B, then latch them into S1 on `in_fire`.
- On `adv`: S2 ← {1, `alu_result_i`, S1.rd, S1.wen}.
- If S2 is not loaded and `out_fire`, S2.valid ← 0.
- S1.valid next:
  - `in_fire` → 1.
  - else `adv` or `flush_i` → 0.
  - else hold.
- `flush_i` clears S1.valid, blocks `in_ready_o`, and suppresses `adv`. S2 is older and drains normally.
- S2 holds its contents stable while `out_valid_o & !out_ready_i`. WBU writes the register file on `out_fire`.
- Reset: S1.valid = S2.valid = 0. All S1/S2 data fields are 0. Outputs: `in_ready_o` = 1, `out_valid_o` = 0, `out_result_o` = 0, `out_rd_o` = 0, `out_wen_o` = 0, `alu_*_o` = 0. Reset asserted mid-operation discards both entries immediately.

## Timing
- `in_fire` at edge k → S1 is valid in cycle k+1.
- With WBU ready: `adv` at edge k+1 → `out_valid_o` high in cycle k+2. Latency is 2 edges.
- Back-to-back dependent instructions run with no bubble: the bypass takes `alu_result_i` from S1 in the same cycle.
- With `out_ready_i` low and both entries full, `in_ready_o` = 0 and all state holds.
- Once `out_ready_i` rises: S2 drains, S1 advances, and a new instruction is accepted, all on the same edge.
- Simultaneous `flush_i` and `in_valid_i`: no accept; S1 cleared.
- Simultaneous `flush_i` and `out_fire`: S2 drains; S1 cleared.

## Test plan
- Reset, then one instruction {op add, rs1 = 5, rs2 = 7, sel 0/0, rd = 3, wen} with `out_ready_i` = 1. Required:
  - `alu_a_o` = 5 and `alu_b_o` = 7 in cycle 1.
  - ALU returns 12; `out_valid_o`, `out_result_o` = 12, `out_rd_o` = 3 in cycle 2.
- Dependent pair: I0 writes x3 = 12; I1 adds x3 + imm 1 the next cycle while the register file still reads 0. Required: I1 `alu_a_o` = 12, I1 result = 13, no bubble.
- Back-pressure: `out_ready_i` = 0 for 4 cycles while 3 instructions are offered. Required:
  - Only 2 are accepted.
  - `in_ready_o` = 0 while both entries are full.
  - S2 stays stable.
  - The third is accepted on the edge `out_ready_i` rises.
- Index-zero bypass: S2 holds rd = 0 with wen; the next instruction reads rs1 = 0 with register-file data 0. Required: operand A = 0, not forwarded.
- Operand selects: pc = 0x8000_0000, sel 1/2. Required: `alu_a_o` = 0x8000_0000 and `alu_b_o` = 4.
- Flush with S1 full and S2 stalled. Required: S1 is dropped, S2 is delivered unchanged. Also: `rst_n` low mid-stream clears `out_valid_o` asynchronously, before the next edge.
